// File: rtl/load_store_unit_pkg.sv
// lsu_pkg: funct3 codes, FSM states, access sizes and alignment helpers for load_store_unit.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [2:0] {IDLE, REQ, REQ_LO, REQ_HI, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, DONE} state_t;
`endif
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
  function automatic size_t f3_size(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? SZ_B : f3[1:0] == 2'b01 ? SZ_H : SZ_W;
  endfunction
  function automatic logic f3_legal(input logic st, input logic [2:0] f3);
    return st ? (f3 inside {F3_B, F3_H, F3_W}) : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction
  function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
    return (sz == SZ_H && off[0]) || (sz == SZ_W && off != 2'b00);
  endfunction
  function automatic logic crosses_word(input size_t sz, input logic [1:0] off);
    return (sz == SZ_H && off == 2'b11) || (sz == SZ_W && off != 2'b00);
  endfunction
endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: store lane steering/strobes and load extraction/extension across a two-word window.
module lsu_align
  import lsu_pkg::*;
(
  input  size_t       sz,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  output logic [7:0]  wstrb8,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);
  logic [31:0] rep;
  logic [63:0] rot, win;
  logic [3:0]  base;
  // Rotating the replicated data serves both words of a split store, strobes pick the lanes.
  always_comb begin
    rep = sz == SZ_B ? {4{wdata[7:0]}} : sz == SZ_H ? {2{wdata[15:0]}} : wdata;
    rot = {rep, rep} << {off, 3'b000};
    wdata_out = rot[63:32];
    base = sz == SZ_B ? 4'b0001 : sz == SZ_H ? 4'b0011 : 4'b1111;
    wstrb8 = {4'b0000, base} << off;
    win = {rd_hi, rd_lo} >> {off, 3'b000};
    rdata_out = sz == SZ_B ? {{24{~uns & win[7]}}, win[7:0]}
              : sz == SZ_H ? {{16{~uns & win[15]}}, win[15:0]} : win[31:0];
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: request/ready data-memory FSM; LSU_MISALIGN_SPLIT_EN enables split misaligned accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);
  state_t      state;
  logic        st_r, uns_r, bad;
  size_t       sz_r, sz_in;
  logic [1:0]  off_r, off_in;
  logic [7:0]  strb8;
  logic [31:0] wdata_rot, ext, rd_lo;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0] lo_r;
  logic [3:0]  strb_hi_r;
  assign bad = !f3_legal(is_store, funct3);
  assign rd_lo = state == REQ_HI ? lo_r : mem_rdata;
`else
  logic unused;
  assign unused = ^strb8[7:4];
  assign bad = !f3_legal(is_store, funct3) || is_misaligned(f3_size(funct3), addr[1:0]);
  assign rd_lo = mem_rdata;
`endif
  assign sz_in = state == IDLE ? f3_size(funct3) : sz_r;
  assign off_in = state == IDLE ? addr[1:0] : off_r;
  lsu_align u_align (
    .sz(sz_in), .uns(uns_r), .off(off_in), .wdata(wdata), .rd_lo(rd_lo), .rd_hi(mem_rdata),
    .wstrb8(strb8), .wdata_out(wdata_rot), .rdata_out(ext)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_wstrb <= '0;
      rdata <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      st_r <= 1'b0;
      uns_r <= 1'b0;
      sz_r <= SZ_B;
      off_r <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      lo_r <= '0;
      strb_hi_r <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          st_r <= is_store;
          uns_r <= funct3[2];
          sz_r <= sz_in;
          off_r <= addr[1:0];
          if (bad) begin
            state <= DONE;
            done <= 1'b1;
            err <= 1'b1;
          end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
            state <= crosses_word(sz_in, addr[1:0]) ? REQ_LO : REQ;
            strb_hi_r <= is_store ? strb8[7:4] : 4'b0000;
`else
            state <= REQ;
`endif
            busy <= 1'b1;
            mem_req <= 1'b1;
            mem_we <= is_store;
            mem_addr <= {addr[WIDTH-1:2], 2'b00};
            mem_wstrb <= is_store ? strb8[3:0] : 4'b0000;
            mem_wdata <= wdata_rot;
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        REQ_LO: if (mem_ready) begin
          state <= REQ_HI;
          lo_r <= mem_rdata;
          mem_addr <= mem_addr + 32'd4;
          mem_wstrb <= strb_hi_r;
        end
        REQ, REQ_HI: if (mem_ready) begin
`else
        REQ: if (mem_ready) begin
`endif
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          mem_req <= 1'b0;
          mem_we <= 1'b0;
          mem_wstrb <= 4'b0000;
          if (!st_r) rdata <= ext;
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
